// File: rtl/new_cache_pkg.sv
// Shared types and defaults for the miss-fill path.
package new_cache_pkg;

    // Default geometry. The fill unit's own parameters override these.
    localparam int unsigned s_offset_def = 5;
    localparam int unsigned s_beat_def   = 64;
    localparam int unsigned s_mask       = 2 ** s_offset_def;
    localparam int unsigned s_line       = 8 * s_mask;
    localparam int unsigned BEATS        = s_line / s_beat_def;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WRITE = 2'd2
    } fill_state_t;

    // A store byte wins over the fill byte when its enable is set.
    function automatic logic [7:0] merge_byte(input logic [7:0] fill_b,
                                              input logic [7:0] store_b,
                                              input logic       be);
        return be ? store_b : fill_b;
    endfunction

endpackage

// File: rtl/fill_line_buffer.sv
// Beat-indexed line register with the store byte-merge mux on its output.
module fill_line_buffer
    import new_cache_pkg::*;
#(
    parameter int unsigned line_w = s_line,
    parameter int unsigned mask_w = s_mask,
    parameter int unsigned beat_w = s_line / BEATS,
    parameter int unsigned cnt_w  = (BEATS > 1) ? $clog2(BEATS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              beat_we_i,
    input  logic [cnt_w-1:0]  beat_idx_i,
    input  logic [beat_w-1:0] beat_data_i,
    input  logic [line_w-1:0] merge_wdata_i,
    input  logic [mask_w-1:0] merge_mbe_i,
    output logic [line_w-1:0] line_o
);

    logic [line_w-1:0] line_q;

    // Drop each arriving beat into its slot of the line.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            line_q <= '0;
        end else if (beat_we_i) begin
            line_q[beat_idx_i * beat_w +: beat_w] <= beat_data_i;
        end
    end

    // Overlay the captured store bytes on the collected line.
    for (genvar i = 0; i < int'(mask_w); i++) begin : g_merge
        assign line_o[8*i +: 8] = merge_byte(line_q[8*i +: 8], merge_wdata_i[8*i +: 8],
                                             merge_mbe_i[i]);
    end

endmodule

// File: rtl/line_fill_unit.sv
// Miss-fill controller: reads a line from memory beat by beat, merges a pending
// store into it and writes the whole line into the data array in one cycle.
module line_fill_unit
    import new_cache_pkg::*;
#(
    parameter int unsigned s_offset = 5,
    parameter int unsigned s_index  = 3,
    parameter int unsigned s_beat   = 64,
    localparam int unsigned line_w  = 8 * (2 ** s_offset),
    localparam int unsigned mask_w  = 2 ** s_offset,
    localparam int unsigned beats   = line_w / s_beat,
    localparam int unsigned cnt_w   = (beats > 1) ? $clog2(beats) : 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fill_req_i,
    input  logic [31:0]        fill_addr_i,
    input  logic [s_index-1:0] fill_index_i,
    input  logic               merge_en_i,
    input  logic [line_w-1:0]  merge_wdata_i,
    input  logic [mask_w-1:0]  merge_mbe_i,
    output logic               pmem_read_o,
    output logic [31:0]        pmem_address_o,
    input  logic [s_beat-1:0]  pmem_rdata_i,
    input  logic               pmem_resp_i,
    output logic [mask_w-1:0]  arr_write_en_o,
    output logic [s_index-1:0] arr_windex_o,
    output logic [line_w-1:0]  arr_datain_o,
    output logic               fill_busy_o,
    output logic               fill_done_o
);

    fill_state_t        state_q;
    logic [cnt_w-1:0]   cnt_q;
    logic [31:0]        addr_q;
    logic [s_index-1:0] index_q;
    logic [line_w-1:0]  wdata_q;
    logic [mask_w-1:0]  mbe_q;
    logic               pmem_read_q;
    logic [mask_w-1:0]  write_en_q;
    logic               done_q;
    logic               beat_we;
    logic               last_beat;
    logic               unused_offset;

    assign unused_offset = ^fill_addr_i[s_offset-1:0];

    assign beat_we   = (state_q == REQ) && pmem_resp_i;
    assign last_beat = (cnt_q == cnt_w'(beats - 1));

    // Fill sequencer: accept, collect beats, one-cycle array write.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            addr_q      <= '0;
            index_q     <= '0;
            wdata_q     <= '0;
            mbe_q       <= '0;
            pmem_read_q <= 1'b0;
            write_en_q  <= '0;
            done_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (fill_req_i) begin
                        state_q     <= REQ;
                        cnt_q       <= '0;
                        addr_q      <= {fill_addr_i[31:s_offset], {s_offset{1'b0}}};
                        index_q     <= fill_index_i;
                        wdata_q     <= merge_wdata_i;
                        mbe_q       <= merge_en_i ? merge_mbe_i : '0;
                        pmem_read_q <= 1'b1;
                    end
                end
                REQ: begin
                    if (pmem_resp_i) begin
                        if (last_beat) begin
                            state_q     <= WRITE;
                            cnt_q       <= '0;
                            pmem_read_q <= 1'b0;
                            write_en_q  <= '1;
                            done_q      <= 1'b1;
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                end
                WRITE: begin
                    state_q    <= IDLE;
                    write_en_q <= '0;
                    done_q     <= 1'b0;
                end
                default: begin
                    state_q     <= IDLE;
                    pmem_read_q <= 1'b0;
                    write_en_q  <= '0;
                    done_q      <= 1'b0;
                end
            endcase
        end
    end

    fill_line_buffer #(
        .line_w (line_w),
        .mask_w (mask_w),
        .beat_w (s_beat),
        .cnt_w  (cnt_w)
    ) u_buf (
        .clk           (clk),
        .rst           (rst),
        .beat_we_i     (beat_we),
        .beat_idx_i    (cnt_q),
        .beat_data_i   (pmem_rdata_i),
        .merge_wdata_i (wdata_q),
        .merge_mbe_i   (mbe_q),
        .line_o        (arr_datain_o)
    );

    assign pmem_read_o    = pmem_read_q;
    assign pmem_address_o = addr_q;
    assign arr_write_en_o = write_en_q;
    assign arr_windex_o   = index_q;
    assign fill_done_o    = done_q;
    assign fill_busy_o    = (state_q != IDLE);

endmodule

// File: tb/tb_line_fill_unit.sv
// Bench for line_fill_unit: table of fills plus stray-response, busy and reset sequences.
module tb_line_fill_unit;

    logic         clk;
    logic         rst;
    logic         fill_req;
    logic [31:0]  fill_addr;
    logic [2:0]   fill_index;
    logic         merge_en;
    logic [255:0] merge_wdata;
    logic [31:0]  merge_mbe;
    logic         pmem_read;
    logic [31:0]  pmem_address;
    logic [63:0]  pmem_rdata;
    logic         pmem_resp;
    logic [31:0]  arr_write_en;
    logic [2:0]   arr_windex;
    logic [255:0] arr_datain;
    logic         fill_busy;
    logic         fill_done;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        logic [31:0]       addr;
        logic [2:0]        idx;
        logic              men;
        logic [31:0]       mbe;
        logic [255:0]      wdata;
        logic [3:0][63:0]  beats;
        logic [3:0][3:0]   gap;
        logic [31:0]       exp_addr;
        logic [255:0]      exp_line;
    } vec_t;

    typedef struct packed {
        logic [2:0]   idx;
        logic [255:0] line;
    } exp_t;

    exp_t exp_q[$];
    vec_t vecs[5];

    line_fill_unit dut (
        .clk            (clk),
        .rst            (rst),
        .fill_req_i     (fill_req),
        .fill_addr_i    (fill_addr),
        .fill_index_i   (fill_index),
        .merge_en_i     (merge_en),
        .merge_wdata_i  (merge_wdata),
        .merge_mbe_i    (merge_mbe),
        .pmem_read_o    (pmem_read),
        .pmem_address_o (pmem_address),
        .pmem_rdata_i   (pmem_rdata),
        .pmem_resp_i    (pmem_resp),
        .arr_write_en_o (arr_write_en),
        .arr_windex_o   (arr_windex),
        .arr_datain_o   (arr_datain),
        .fill_busy_o    (fill_busy),
        .fill_done_o    (fill_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // Scoreboard: every array write must match the oldest expected fill.
    always @(negedge clk) begin
        if (!rst) begin
            if (arr_write_en !== 32'h0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_bad++;
                    $display("FAIL unexpected_write: got index %0d with no fill outstanding", arr_windex);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("write_index", 256'(arr_windex), 256'(e.idx));
                    chk("write_data", arr_datain, e.line);
                    chk("write_en", 256'(arr_write_en), 256'(32'hFFFF_FFFF));
                    chk("done_with_write", 256'(fill_done), 256'(1'b1));
                end
            end else if (fill_done === 1'b1) begin
                n_cmp++;
                n_bad++;
                $display("FAIL stray_done: got fill_done 1 want 0 without a write");
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory responses with nothing outstanding.
    task automatic stray_resp(input int n);
        for (int i = 0; i < n; i++) begin
            pmem_resp  = 1'b1;
            pmem_rdata = {$urandom, $urandom};
            tick();
            chk("stray_busy", 256'(fill_busy), 256'(1'b0));
            chk("stray_read", 256'(pmem_read), 256'(1'b0));
        end
        pmem_resp = 1'b0;
    endtask

    // Full fill: accept, beats with gaps, write cycle, back to IDLE.
    // noisy toggles fill_req and the address/merge inputs while busy.
    task automatic run_fill(input vec_t v, input bit noisy);
        fill_req    = 1'b1;
        fill_addr   = v.addr;
        fill_index  = v.idx;
        merge_en    = v.men;
        merge_mbe   = v.mbe;
        merge_wdata = v.wdata;
        exp_q.push_back('{idx: v.idx, line: v.exp_line});
        tick();
        fill_req    = 1'b0;
        fill_addr   = ~v.addr;
        fill_index  = ~v.idx;
        merge_en    = ~v.men;
        merge_mbe   = ~v.mbe;
        merge_wdata = ~v.wdata;
        chk("accept_read", 256'(pmem_read), 256'(1'b1));
        chk("accept_addr", 256'(pmem_address), 256'(v.exp_addr));
        chk("accept_busy", 256'(fill_busy), 256'(1'b1));
        for (int k = 0; k < 4; k++) begin
            for (int g = 0; g < int'(v.gap[k]); g++) begin
                if (noisy) fill_req = ~fill_req;
                tick();
                chk("gap_read", 256'(pmem_read), 256'(1'b1));
            end
            if (noisy) fill_req = ~fill_req;
            pmem_resp  = 1'b1;
            pmem_rdata = v.beats[k];
            tick();
            pmem_resp  = 1'b0;
            pmem_rdata = {$urandom, $urandom};
            if (noisy) chk("noisy_addr", 256'(pmem_address), 256'(v.exp_addr));
        end
        fill_req = 1'b0;
        chk("last_read_drop", 256'(pmem_read), 256'(1'b0));
        chk("write_latency", 256'(arr_write_en), 256'(32'hFFFF_FFFF));
        tick();
        chk("idle_busy", 256'(fill_busy), 256'(1'b0));
        chk("idle_done", 256'(fill_done), 256'(1'b0));
        chk("idle_we", 256'(arr_write_en), 256'(32'h0));
        chk("sb_drained", 256'(exp_q.size()), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t rv;

        vecs[0] = '{32'h0000_1234, 3'd3, 1'b0, 32'h0, 256'h0,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111},
                    {4'd0, 4'd0, 4'd0, 4'd0}, 32'h0000_1220,
                    {64'h4444_4444_4444_4444, 64'h3333_3333_3333_3333,
                     64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}};
        vecs[1] = '{32'h0000_ABFF, 3'd1, 1'b0, 32'h0, 256'h0,
                    {64'hD4D4_D4D4_D4D4_D4D4, 64'hC3C3_C3C3_C3C3_C3C3,
                     64'hB2B2_B2B2_B2B2_B2B2, 64'hA1A1_A1A1_A1A1_A1A1},
                    {4'd3, 4'd0, 4'd3, 4'd2}, 32'h0000_ABE0,
                    {64'hD4D4_D4D4_D4D4_D4D4, 64'hC3C3_C3C3_C3C3_C3C3,
                     64'hB2B2_B2B2_B2B2_B2B2, 64'hA1A1_A1A1_A1A1_A1A1}};
        vecs[2] = '{32'h8000_0040, 3'd6, 1'b1, 32'h0000_000F, {{28{8'hFF}}, 32'hDEAD_BEEF},
                    {64'h3132_3334_3536_3738, 64'h2122_2324_2526_2728,
                     64'h1112_1314_1516_1718, 64'h0102_0304_0506_0708},
                    {4'd0, 4'd1, 4'd0, 4'd0}, 32'h8000_0040,
                    {64'h3132_3334_3536_3738, 64'h2122_2324_2526_2728,
                     64'h1112_1314_1516_1718, 64'h0102_0304_DEAD_BEEF}};
        vecs[3] = '{32'hFFFF_FFFF, 3'd7, 1'b0, 32'hFFFF_FFFF, {32{8'h55}},
                    {64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F,
                     64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF},
                    {4'd0, 4'd0, 4'd0, 4'd1}, 32'hFFFF_FFE0,
                    {64'hF0F0_F0F0_F0F0_F0F0, 64'h0F0F_0F0F_0F0F_0F0F,
                     64'hFEDC_BA98_7654_3210, 64'h0123_4567_89AB_CDEF}};
        vecs[4] = '{32'h0000_0100, 3'd0, 1'b1, 32'h8000_0001, {8'hAB, {30{8'h00}}, 8'hCD},
                    {64'hC0C1_C2C3_C4C5_C6C7, 64'hD0D1_D2D3_D4D5_D6D7,
                     64'hE0E1_E2E3_E4E5_E6E7, 64'hF0F1_F2F3_F4F5_F6F7},
                    {4'd1, 4'd0, 4'd2, 4'd0}, 32'h0000_0100,
                    {64'hABC1_C2C3_C4C5_C6C7, 64'hD0D1_D2D3_D4D5_D6D7,
                     64'hE0E1_E2E3_E4E5_E6E7, 64'hF0F1_F2F3_F4F5_F6CD}};

        rst = 1'b1;
        fill_req = 1'b0;
        fill_addr = 32'h0;
        fill_index = 3'd0;
        merge_en = 1'b0;
        merge_wdata = '0;
        merge_mbe = '0;
        pmem_rdata = '0;
        pmem_resp = 1'b0;
        #2;
        chk("rst_read", 256'(pmem_read), 256'(1'b0));
        chk("rst_busy", 256'(fill_busy), 256'(1'b0));
        chk("rst_done", 256'(fill_done), 256'(1'b0));
        chk("rst_we", 256'(arr_write_en), 256'(32'h0));
        chk("rst_addr", 256'(pmem_address), 256'(32'h0));
        chk("rst_windex", 256'(arr_windex), 256'(3'd0));
        chk("rst_datain", arr_datain, 256'h0);
        tick();
        tick();
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) run_fill(vecs[i], 1'b0);

        // Stray responses in IDLE, then a fill with fill_req toggling while busy.
        stray_resp(2);
        run_fill(vecs[0], 1'b1);
        tick();
        chk("no_second_fill", 256'(fill_busy), 256'(1'b0));

        // Reset after two beats of a fill to index 2.
        fill_req = 1'b1;
        fill_addr = 32'h0000_2000;
        fill_index = 3'd2;
        merge_en = 1'b1;
        merge_mbe = 32'hFFFF_FFFF;
        merge_wdata = {32{8'h77}};
        tick();
        fill_req = 1'b0;
        for (int k = 0; k < 2; k++) begin
            pmem_resp = 1'b1;
            pmem_rdata = {$urandom, $urandom};
            tick();
        end
        pmem_resp = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("arst_read", 256'(pmem_read), 256'(1'b0));
        chk("arst_busy", 256'(fill_busy), 256'(1'b0));
        chk("arst_addr", 256'(pmem_address), 256'(32'h0));
        chk("arst_windex", 256'(arr_windex), 256'(3'd0));
        chk("arst_datain", arr_datain, 256'h0);
        chk("arst_we", 256'(arr_write_en), 256'(32'h0));
        tick();
        rst = 1'b0;
        stray_resp(1);
        rv = vecs[1];
        rv.idx = 3'd5;
        rv.gap = {4'd0, 4'd0, 4'd0, 4'd0};
        run_fill(rv, 1'b0);

        repeat (3) tick();
        chk("final_sb_empty", 256'(exp_q.size()), 256'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
